// File: rtl/nios_setup_v2_led_out.sv
// nios_setup_v2_led_out
// Avalon-MM output PIO slave driving board LEDs from the Nios II system.
// Software writes the LED pattern directly (DATA) or sets/clears bits
// atomically (OUTSET/OUTCLEAR). Any bit selected in BLINK_EN is XORed with
// a free-running prescaler phase, so it blinks without CPU involvement.
// Reads have a fixed one-cycle latency and there are no wait states.

module nios_setup_v2_led_out #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter logic [31:0] BLINK_DIV   = 32'd25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Register map word addresses.
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_DIV      = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Reset pattern trimmed to the port width.
    localparam logic [WIDTH-1:0] RESET_BITS = RESET_VALUE[WIDTH-1:0];

    // Architectural registers and their next-state values.
    logic [WIDTH-1:0] data_q,     data_d;
    logic [WIDTH-1:0] blink_en_q, blink_en_d;
    logic [31:0]      div_q,      div_d;

    // Prescaler state.
    logic [31:0]      count_q,    count_d;
    logic             phase_q,    phase_d;

    // Registered outputs.
    logic [WIDTH-1:0] out_q,      out_d;
    logic [31:0]      rdata_q,    rdata_d;

    // Write strobe decode.
    logic             wr_en;
    logic             div_wr;
    logic [WIDTH-1:0] wr_bits;

    assign wr_en   = chipselect & ~write_n;
    assign div_wr  = wr_en && (address == ADDR_DIV);
    assign wr_bits = writedata[WIDTH-1:0];

    // Register file next-state: direct loads and atomic set/clear of DATA.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        data_d     = data_q;
        blink_en_d = blink_en_q;
        div_d      = div_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = wr_bits;
                ADDR_BLINK_EN: blink_en_d = wr_bits;
                ADDR_DIV:      div_d      = writedata;
                ADDR_OUTSET:   data_d     = data_q | wr_bits;
                ADDR_OUTCLEAR: data_d     = data_q & ~wr_bits;
                default:       ;  // STATUS and reserved slots ignore writes
            endcase
        end
    end

    // Prescaler next-state: a DIV write restarts the blink cleanly and takes
    // priority over a terminal count in the same cycle.
    always_comb begin
        count_d = count_q + 32'd1;
        phase_d = phase_q;
        if (div_wr) begin
            count_d = 32'd0;
            phase_d = 1'b0;
        end else if (count_q == div_q) begin
            count_d = 32'd0;
            phase_d = ~phase_q;
        end
    end

    // LED drive is built from the values being loaded this edge, so a write
    // or a phase change shows on out_port after that same edge.
    always_comb begin
        out_d = data_d ^ (blink_en_d & {WIDTH{phase_d}});
    end

    // Read mux: zero-extended selected register, sampled every cycle.
    always_comb begin
        rdata_d = 32'd0;
        case (address)
            ADDR_DATA:     rdata_d[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN: rdata_d[WIDTH-1:0] = blink_en_q;
            ADDR_DIV:      rdata_d            = div_q;
            ADDR_STATUS:   rdata_d[0]         = phase_q;
            default:       ;  // write-only and reserved slots read as zero
        endcase
    end

    // State update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_BITS;
            blink_en_q <= '0;
            div_q      <= BLINK_DIV;
            count_q    <= 32'd0;
            phase_q    <= 1'b0;
            out_q      <= RESET_BITS;
            rdata_q    <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            div_q      <= div_d;
            count_q    <= count_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
            rdata_q    <= rdata_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rdata_q;

endmodule

// File: doc/nios_setup_v2_led_out.md
# nios_setup_v2_led_out

Avalon-MM output PIO slave that drives board LEDs from the Nios II system. It is the write-side counterpart of the switch input PIO on the same system interconnect. Software can write the output pattern directly, or set and clear individual bits atomically. Any bit can also be made to blink from a free-running prescaler, with no CPU involvement.

## Interface
- WIDTH, 8, number of output bits (1..32)
- RESET_VALUE, 0, out_port and DATA value after reset
- BLINK_DIV, 25000000, reset value of the DIV register (blink half-period minus 1, in clk cycles)

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- chipselect  in  1  Avalon slave select
- address  in  3  word address of the register
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data, 1-cycle read latency, 0 wait states
- out_port  out  WIDTH  registered LED drive

## Operation
- Reset: all registers take their reset values asynchronously when reset_n is low.
  - DATA = RESET_VALUE
  - BLINK_EN = 0
  - DIV = BLINK_DIV
  - count = 0, phase = 0
  - readdata = 0, out_port = RESET_VALUE
- A write occurs on a clk edge where chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used, except for DIV, which uses the full 32 bits.
- Register map:
  - 0 DATA, R/W: DATA <= writedata.
  - 1 BLINK_EN, R/W: per-bit blink mask.
  - 2 DIV, R/W, 32-bit. A write also forces count to 0 and phase to 0.
  - 3 STATUS, RO: bit0 = phase, other bits 0. Writes are ignored.
  - 4 OUTSET, WO: DATA <= DATA | writedata. Reads return 0.
  - 5 OUTCLEAR, WO: DATA <= DATA & ~writedata. Reads return 0.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- Prescaler, running every cycle:
  - If count == DIV: count <= 0 and phase <= ~phase.
  - Otherwise: count <= count + 1.
  - DIV=0 toggles phase every cycle.
  - A DIV write in the same cycle as a terminal count wins: count=0, phase=0.
- out_port <= DATA_next ^ (BLINK_EN_next & {WIDTH{phase_next}}). These are the register values being loaded on the same edge.
- Read mux:
  - readdata <= zero-extended register selected by address, updated every cycle regardless of chipselect.
  - Unselected and unused upper bits are 0.
- Writing BLINK_EN does not disturb count or phase. A newly enabled bit blinks in the current phase immediately.
- Clearing a BLINK_EN bit returns that output to its DATA value on the next out_port update.

## Timing
- Write at edge N: the register holds its new value after edge N, and out_port reflects it after the same edge N.
- Read: address presented in the cycle before edge N; readdata is valid after edge N (latency 1). A read of DATA in the cycle following a DATA write returns the new value.
- Blink: phase toggles every DIV+1 cycles, so the full blink period is 2*(DIV+1) cycles.
- reset_n assertion mid-operation forces all outputs and registers to reset values immediately, with no clock needed. On deassertion, the first count increment occurs on the first clk edge.
- No back-pressure: waitrequest is not provided, and every access completes in one cycle.

## Test plan
- Reset check: assert reset_n=0 mid-run, with RESET_VALUE=8'hA5 → out_port=8'hA5 and readdata=0 asynchronously; DATA reads back 8'hA5 after release.
- Write 8'h3C to DATA, then OUTSET 8'h81, then OUTCLEAR 8'h0C → out_port goes 3C, BD, B1, each one edge after its write; reads of 4 and 5 return 0.
- DIV=3, BLINK_EN=8'h0F, DATA=8'h00 → out_port alternates 00 / 0F every 4 cycles; STATUS bit0 tracks the phase.
- DIV=0 → phase toggles every cycle. Then write DIV=5 on a terminal-count cycle → count=0, phase=0, and the next toggle comes 6 cycles later.
- Write with chipselect=0, or to address 3, 6 or 7 → no register change. Reads from 6 and 7 return 0.
- Back-to-back cycles: a DATA write immediately followed by a DATA read → readdata equals the written value one cycle after the read address is presented.
